// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read streamer and its skid buffer.
package fifo_pkg;

   localparam int SKID_DEPTH         = 3;
   localparam int DEFAULT_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2,
      S3 = 2'd3
   } occ_e;

   // A read may only be launched if the word can never find the skid buffer full.
   function automatic logic credit_ok(input occ_e occ, input logic inflight);
      return ({1'b0, occ} + {2'b00, inflight}) < 3'(SKID_DEPTH);
   endfunction

   function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
      return (ptr == 2'(SKID_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
   endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Three-entry skid FIFO between the FIFO read port and the ready/valid stream.
module fifo_rd_skid
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  rclk,
   input  logic                  r_rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  valid,
   output occ_e                  occ
);

   logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
   logic [1:0]            wr_ptr_q, wr_ptr_d;
   logic [1:0]            rd_ptr_q, rd_ptr_d;
   occ_e                  occ_q, occ_d;
   logic                  pop_ok;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      pop_ok   = pop && (occ_q != S0);

      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end

      unique case (occ_q)
         S0: if (push) occ_d = S1;
         S1: if (push && !pop_ok) occ_d = S2; else if (!push && pop_ok) occ_d = S0;
         S2: if (push && !pop_ok) occ_d = S3; else if (!push && pop_ok) occ_d = S1;
         S3: if (!push && pop_ok) occ_d = S2;
      endcase
   end

   always_ff @(posedge rclk) begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      if (r_rst) begin
         occ_q    <= S0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         occ_q    <= occ_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is not reset; the head is masked to zero while empty instead.
   always_ff @(posedge rclk) begin
      mem_q <= mem_d;
   end

   assign pop_data = (occ_q != S0) ? mem_q[rd_ptr_q] : '0;
   assign valid    = (occ_q != S0);
   assign occ      = occ_q;

   // The read credit rule must make a write into a full buffer impossible.
   assert property (@(posedge rclk) disable iff (r_rst) !(push && occ_q == S3));

endmodule

// File: rtl/fifo_read_streamer.sv
// Issues FIFO reads against a credit of skid slots and streams the words out.
module fifo_read_streamer
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  rclk,
   input  logic                  r_rst,
   input  logic                  enable,
   input  logic                  empty,
   input  logic [DATA_WIDTH-1:0] data_out,
   output logic                  ren,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   output logic [CNT_WIDTH-1:0]  rd_count
);

   logic                 inflight_q, inflight_d;
   logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d;
   occ_e                 occ;
   logic                 pop;

   // The credit counts the word still in flight, so ren never looks at m_ready.
   always_comb begin
      ren        = !r_rst && enable && !empty && credit_ok(occ, inflight_q);
      inflight_d = ren;
      pop        = m_valid && m_ready;
      rd_count_d = rd_count_q;
      if (pop) begin
         rd_count_d = rd_count_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge rclk) begin
      if (r_rst) begin
         inflight_q <= 1'b0;
         rd_count_q <= '0;
      end else begin
         inflight_q <= inflight_d;
         rd_count_q <= rd_count_d;
      end
   end

   fifo_rd_skid #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_skid (
      .rclk     (rclk),
      .r_rst    (r_rst),
      .push     (inflight_q),
      .push_data(data_out),
      .pop      (pop),
      .pop_data (m_data),
      .valid    (m_valid),
      .occ      (occ)
   );

   assign rd_count = rd_count_q;

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Randomized and directed bench for fifo_read_streamer with a queue-based reference model.
module tb_fifo_read_streamer;

   logic        rclk = 1'b0;
   logic        r_rst;
   logic        enable;
   logic        empty;
   logic [7:0]  data_out;
   logic        m_ready;
   logic        ren, m_valid;
   logic [7:0]  m_data;
   logic [15:0] rd_count;
   logic        ren_w, m_valid_w;
   logic [7:0]  m_data_w;
   logic [3:0]  rd_count_w;

   always #5 rclk = ~rclk;

   fifo_read_streamer dut (
      .rclk(rclk), .r_rst(r_rst), .enable(enable), .empty(empty), .data_out(data_out),
      .ren(ren), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .rd_count(rd_count)
   );

   // Narrow counter copy on the same stimulus, to exercise the counter wrap cheaply.
   fifo_read_streamer #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_w4 (
      .rclk(rclk), .r_rst(r_rst), .enable(enable), .empty(empty), .data_out(data_out),
      .ren(ren_w), .m_valid(m_valid_w), .m_data(m_data_w), .m_ready(m_ready), .rd_count(rd_count_w)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // Reference model: the external FIFO contents, the words owed to the stream, and counts.
   logic [7:0]  src[$];
   logic [7:0]  exp_q[$];
   int          issued, popped, iss_prev, ren_cnt, since_rel;
   logic [15:0] cnt_model;
   bit          force_empty, rst_prev, stall_prev;
   logic [7:0]  hold_data, next_word, want;
   logic [31:0] ren_mask, valid_mask;

   task automatic push_src(input int n);
      repeat (n) begin
         src.push_back(next_word);
         next_word++;
      end
   endtask

   task automatic cycle();
      logic ren_s, hs, exp_ren;
      empty = force_empty || (src.size() == 0);
      @(negedge rclk);
      ren_s = ren;
      hs    = 1'b0;
      if (rst_prev) begin
         check("rst_valid", m_valid, 0);
         check("rst_data", m_data, 0);
         check("rst_count", rd_count, 0);
      end
      if (r_rst) begin
         check("rst_ren", ren, 0);
         since_rel = 0;
      end else begin
         since_rel++;
         if (since_rel < 32) begin
            ren_mask[since_rel]   = ren;
            valid_mask[since_rel] = m_valid;
         end
         exp_ren = enable && !empty && ((issued - popped) < 3);
         check("ren", ren, exp_ren);
         check("ren_w4", ren_w, exp_ren);
         if (iss_prev > popped) begin
            check("latency", m_valid, 1);
            check("latency_w4", m_valid_w, 1);
         end
         if (stall_prev) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, hold_data);
         end
         check("count", rd_count, cnt_model);
         check("count_w4", rd_count_w, cnt_model[3:0]);
         hs = m_valid && m_ready;
         if (hs) begin
            if (exp_q.size() == 0) check("extra_word", m_valid, 0);
            else begin
               want = exp_q.pop_front();
               check("data", m_data, want);
               check("data_w4", m_data_w, want);
            end
         end
         stall_prev = m_valid && !m_ready;
         hold_data  = m_data;
         iss_prev   = issued;
      end
      @(posedge rclk);
      #1;
      if (r_rst) begin
         issued = 0; popped = 0; iss_prev = 0; cnt_model = '0; stall_prev = 0;
         exp_q.delete();
      end else begin
         if (ren_s) begin
            ren_cnt++;
            if (src.size() > 0) begin
               data_out = src.pop_front();
               exp_q.push_back(data_out);
            end else data_out = 8'hEE;
            issued++;
         end
         if (hs) begin
            popped++;
            cnt_model++;
         end
      end
      rst_prev = r_rst;
   endtask

   initial begin
      int base_ren;
      logic [15:0] base_cnt;
      r_rst = 1'b1; enable = 1'b1; m_ready = 1'b1; data_out = '0; force_empty = 0;
      issued = 0; popped = 0; iss_prev = 0; ren_cnt = 0; since_rel = 0; cnt_model = '0;
      rst_prev = 0; stall_prev = 0; hold_data = '0; next_word = 8'h40;

      // Reset release with three words queued.
      src.push_back(8'h11); src.push_back(8'h22); src.push_back(8'h33);
      repeat (2) cycle();
      ren_mask = '0; valid_mask = '0;
      r_rst = 1'b0;
      repeat (8) cycle();
      check("s1_ren_cycles", ren_mask, 32'h0000_000E);
      check("s1_valid_cycles", valid_mask, 32'h0000_0038);
      check("s1_count", rd_count, 3);

      // Consumer stalled with five words available.
      m_ready = 1'b0;
      base_ren = ren_cnt;
      push_src(5);
      repeat (8) cycle();
      check("s2_reads", ren_cnt - base_ren, 3);
      check("s2_head_valid", m_valid, 1);
      check("s2_head_data", m_data, 8'h40);
      m_ready = 1'b1;
      repeat (10) cycle();

      // enable dropped in the same cycle as a read.
      enable = 1'b0;
      push_src(4);
      cycle();
      base_ren = ren_cnt;
      base_cnt = rd_count;
      enable = 1'b1;
      cycle();
      enable = 1'b0;
      repeat (6) cycle();
      check("s3_single_read", ren_cnt - base_ren, 1);
      check("s3_delivered", rd_count, base_cnt + 16'd1);
      enable = 1'b1;
      repeat (8) cycle();

      // Reset with two words buffered and one in flight.
      m_ready = 1'b0;
      push_src(5);
      repeat (3) cycle();
      check("s4_pre_valid", m_valid, 1);
      r_rst = 1'b1;
      cycle();
      r_rst = 1'b0;
      cycle();
      m_ready = 1'b1;
      repeat (10) cycle();

      // Empty flag toggling every cycle.
      push_src(30);
      for (int i = 0; i < 60; i++) begin
         force_empty = ~force_empty;
         m_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      force_empty = 0;
      m_ready = 1'b1;
      repeat (40) cycle();

      // Random traffic with occasional resets.
      for (int i = 0; i < 500; i++) begin
         enable      = ($urandom_range(0, 9) != 0);
         m_ready     = ($urandom_range(0, 3) != 0);
         force_empty = ($urandom_range(0, 4) == 0);
         r_rst       = ($urandom_range(0, 99) == 0);
         if (src.size() < 4) push_src($urandom_range(0, 3));
         cycle();
      end
      r_rst = 1'b0; enable = 1'b1; m_ready = 1'b1; force_empty = 0;
      repeat (20) cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fifo_read_streamer.md
FIFO_READ_STREAMER -- requirements
Module: fifo_read_streamer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the FIFO and stream word width.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, the width of the delivered-word counter.
REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-004 The block SHALL have port rclk  input  1  read-domain clock; all logic on the rising edge.
REQ-005 The block SHALL have port r_rst  input  1  synchronous active-high reset.
REQ-006 The block SHALL have port enable  input  1  when low, no new FIFO reads are issued.
REQ-007 The block SHALL have port empty  input  1  FIFO empty flag, registered in rclk domain.
REQ-008 The block SHALL have port data_out  input  DATA_WIDTH  FIFO read data, valid the cycle after ren.
REQ-009 The block SHALL have port ren  output  1  FIFO read enable.
REQ-010 The block SHALL have port m_valid  output  1  stream word valid.
REQ-011 The block SHALL have port m_data  output  DATA_WIDTH  stream word.
REQ-012 The block SHALL have port m_ready  input  1  stream consumer ready.
REQ-013 The block SHALL have port rd_count  output  CNT_WIDTH  count of words accepted on the stream.

Function
REQ-014 The block SHALL drive ren = enable & ~empty & (occ + inflight < 3), where occ is skid occupancy (0..3) and inflight is a 1-bit flag.
REQ-015 ren SHALL NOT depend combinationally on m_ready; ren SHALL never be high while empty is high.
REQ-016 inflight SHALL be set the cycle after ren is high and cleared otherwise.
REQ-017 When inflight is high, data_out SHALL be written into the skid buffer at that rising edge.
REQ-018 Latency SHALL be: ren high in cycle N gives m_valid high with that word no later than cycle N+2.
REQ-019 The skid buffer SHALL be a 3-entry FIFO with occupancy states S0, S1, S2, S3.
REQ-020 Each cycle, occ SHALL change by +1 on a write only, -1 on a pop only, and 0 on both or neither.
REQ-021 A pop SHALL occur when m_valid & m_ready; m_valid = (occ != 0); m_data = head entry.
REQ-022 m_data and m_valid SHALL hold stable while m_valid & ~m_ready.
REQ-023 The REQ-014 credit rule SHALL guarantee no write in S3; an overflow attempt is a design error (assertion).
REQ-024 A simultaneous write and pop in S0 SHALL NOT bypass: the word is written and appears on m_valid the next cycle.
REQ-025 Sustained throughput SHALL be one word per cycle when empty=0, enable=1 and m_ready=1.
REQ-026 rd_count SHALL increment by 1 on each pop and wrap modulo 2^CNT_WIDTH.
REQ-027 enable going low SHALL only block new ren; an inflight word SHALL still be captured and delivered.
REQ-028 Word order SHALL be preserved exactly from FIFO to stream.

Reset
REQ-029 While r_rst is high: ren=0, inflight=0, occ=0 (S0), m_valid=0, m_data=0, rd_count=0.
REQ-030 Reset mid-operation SHALL discard the inflight word and all buffered words; the block is not required to recover them.
REQ-031 The first ren SHALL be issued no earlier than the first cycle after r_rst deasserts.

Structure
REQ-032 Package fifo_pkg SHALL hold the SKID_DEPTH=3 constant, the occupancy typedef (2 bits), and the default DATA_WIDTH.
REQ-033 The skid buffer SHALL be sub-module fifo_rd_skid (push, pop, data, occ); fifo_read_streamer holds the ren/credit logic and rd_count.

Verification
REQ-034 Reset release with empty=0, enable=1, m_ready=1, and FIFO holding 0x11,0x22,0x33 SHALL produce ren in cycles 1-3, m_valid in cycles 3-5 with data 0x11,0x22,0x33, and rd_count=3.
REQ-035 m_ready=0 with 5 words available SHALL cause ren to stop after 3 reads, occ=3 and inflight=0; m_data SHALL stay at the first word until m_ready rises.
REQ-036 With empty toggling every cycle, ren SHALL never be high while empty=1, and no word SHALL be duplicated or lost (scoreboard).
REQ-037 Dropping enable in the same cycle as ren=1 SHALL still deliver that word; no further ren SHALL occur while enable=0.
REQ-038 Asserting r_rst with occ=2 and inflight=1 SHALL give m_valid=0 and rd_count=0 the next cycle; the word stream resumes cleanly after release.
REQ-039 With rd_count preset at 0xFFFF, a single pop SHALL wrap rd_count to 0x0000.
